// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer: registered N-mode digit mux with manual select,
// timed auto-cycle and a blanking interval on every mode switch.
// Optional per-digit blinking is built when DISP_MODE_BLINK_EN is defined.
module display_mode_sequencer #(
    parameter int NUM_MODES = 4,
    parameter int NUM_DIGITS = 6,
    parameter int DIGIT_W = 5,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLANK_CYCLES = 1000,
    parameter logic [DIGIT_W-1:0] BLANK_CODE = 5'b11111,
    localparam int SEL_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_MODES*NUM_DIGITS*DIGIT_W-1:0] mode_data,
    input  logic [SEL_W-1:0]                      sel_in,
    input  logic                                  auto_en,
    input  logic                                  advance,
`ifdef DISP_MODE_BLINK_EN
    input  logic [NUM_DIGITS-1:0]                 blink_mask,
    input  logic [15:0]                           blink_period,
`endif
    output logic [NUM_DIGITS*DIGIT_W-1:0]         seg_data,
    output logic [SEL_W-1:0]                      cur_mode,
    output logic                                  switch_pulse
);

    localparam int SEG_W = NUM_DIGITS * DIGIT_W;
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST =
        (BLANK_CYCLES > 0) ? BL_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_MODE = SEL_W'(NUM_MODES - 1);
    localparam logic [SEL_W:0] MODE_CNT = (SEL_W + 1)'(NUM_MODES);
    localparam logic [SEG_W-1:0] BLANK_WORD = {NUM_DIGITS{BLANK_CODE}};

    typedef enum logic {
        S_SHOW,
        S_BLANK
    } state_t;

    state_t state_q, state_d;
    logic [SEL_W-1:0] cur_mode_q, cur_mode_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [BL_W-1:0] blank_q, blank_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic pulse_q, pulse_d;

    logic [SEG_W-1:0] mode_arr [NUM_MODES];
    logic [SEL_W-1:0] next_mode;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] show_mode;
    logic [SEG_W-1:0] raw_data;
    logic [SEG_W-1:0] show_data;
    logic sel_ok;
    logic man_req;
    logic auto_req;
    logic req;

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        assign mode_arr[m] = mode_data[m*SEG_W +: SEG_W];
    end

    // Decide whether a switch is requested this clock and which mode it targets.
    always_comb begin
        next_mode = (cur_mode_q == LAST_MODE) ? '0 : cur_mode_q + SEL_W'(1);
        sel_ok = {1'b0, sel_in} < MODE_CNT;
        man_req = sel_ok && (sel_in != cur_mode_q);
        auto_req = advance || (dwell_q == DW_LAST);
        req = 1'b0;
        target = cur_mode_q;
        unique case (1'b1)
            auto_en: begin
                req = auto_req;
                target = next_mode;
            end
            default: begin
                req = man_req;
                target = sel_in;
            end
        endcase
        // Without blanking the new mode is loaded on the same edge as the request.
        show_mode = cur_mode_q;
        if (BLANK_CYCLES == 0 && state_q == S_SHOW && req) begin
            show_mode = target;
        end
        raw_data = mode_arr[show_mode];
    end

`ifdef DISP_MODE_BLINK_EN
    logic [15:0] ph_cnt_q, ph_cnt_d;
    logic phase_q, phase_d;

    // Free-running blink phase, toggling every blink_period+1 clocks.
    always_comb begin
        ph_cnt_d = ph_cnt_q + 16'd1;
        phase_d = phase_q;
        if (ph_cnt_q >= blink_period) begin
            ph_cnt_d = '0;
            phase_d = ~phase_q;
        end
    end

    // Masked digits show the blank code during the off phase.
    always_comb begin
        show_data = raw_data;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (phase_q && blink_mask[d]) begin
                show_data[d*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            ph_cnt_q <= ph_cnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign show_data = raw_data;
`endif

    // Next-state and registered-output logic for the show/blank sequencer.
    always_comb begin
        state_d = state_q;
        cur_mode_d = cur_mode_q;
        dwell_d = dwell_q;
        blank_d = blank_q;
        seg_d = seg_q;
        pulse_d = 1'b0;
        unique case (state_q)
            S_SHOW: begin
                seg_d = show_data;
                dwell_d = auto_en ? dwell_q + DW_W'(1) : '0;
                if (req) begin
                    cur_mode_d = target;
                    dwell_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = S_BLANK;
                        blank_d = '0;
                        seg_d = BLANK_WORD;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                seg_d = BLANK_WORD;
                dwell_d = '0;
                if (blank_q == BL_LAST) begin
                    state_d = S_SHOW;
                    blank_d = '0;
                    seg_d = show_data;
                    pulse_d = 1'b1;
                end else begin
                    blank_d = blank_q + BL_W'(1);
                end
            end
            default: begin
                state_d = S_SHOW;
            end
        endcase
    end

    // Sequencer state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SHOW;
            cur_mode_q <= '0;
            dwell_q <= '0;
            blank_q <= '0;
            seg_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_mode_q <= cur_mode_d;
            dwell_q <= dwell_d;
            blank_q <= blank_d;
            seg_q <= seg_d;
            pulse_q <= pulse_d;
        end
    end

    assign seg_data = seg_q;
    assign cur_mode = cur_mode_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Bench for display_mode_sequencer: table-driven cycle vectors on a
// blanking build and a zero-blank build, checked through a scoreboard.
module tb_display_mode_sequencer;

    localparam int NM = 3;
    localparam int ND = 6;
    localparam int DW = 5;
    localparam int SW = 2;
    localparam int SEGW = ND * DW;

    localparam int VZ = 0;
    localparam int VM0 = 1;
    localparam int VM1 = 2;
    localparam int VM2 = 3;
    localparam int VB = 4;

    typedef struct {
        logic rst_n;
        logic auto_en;
        logic [SW-1:0] sel;
        logic adv;
        logic [SW-1:0] cur;
        int view;
        logic pulse;
    } vec_t;

    typedef struct {
        logic [SEGW-1:0] seg;
        logic [SW-1:0] cur;
        logic pulse;
    } exp_t;

    logic clk = 1'b0;
    logic [NM*ND*DW-1:0] mode_data;

    logic rst_a = 1'b0;
    logic auto_a = 1'b0;
    logic adv_a = 1'b0;
    logic [SW-1:0] sel_a = '0;
    logic [SEGW-1:0] seg_a;
    logic [SW-1:0] cur_a;
    logic pulse_a;

    logic rst_b = 1'b0;
    logic auto_b = 1'b0;
    logic adv_b = 1'b0;
    logic [SW-1:0] sel_b = '0;
    logic [SEGW-1:0] seg_b;
    logic [SW-1:0] cur_b;
    logic pulse_b;

    vec_t tab_a[$];
    vec_t tab_b[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_mode_sequencer #(
        .NUM_MODES(NM),
        .NUM_DIGITS(ND),
        .DIGIT_W(DW),
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut_a (
        .clk(clk),
        .rst_n(rst_a),
        .mode_data(mode_data),
        .sel_in(sel_a),
        .auto_en(auto_a),
        .advance(adv_a),
        .seg_data(seg_a),
        .cur_mode(cur_a),
        .switch_pulse(pulse_a)
    );

    display_mode_sequencer #(
        .NUM_MODES(NM),
        .NUM_DIGITS(ND),
        .DIGIT_W(DW),
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(0)
    ) dut_b (
        .clk(clk),
        .rst_n(rst_b),
        .mode_data(mode_data),
        .sel_in(sel_b),
        .auto_en(auto_b),
        .advance(adv_b),
        .seg_data(seg_b),
        .cur_mode(cur_b),
        .switch_pulse(pulse_b)
    );

    function automatic logic [4:0] digit_val(int m, int d);
        return 5'(m * 7 + d + 1);
    endfunction

    function automatic logic [SEGW-1:0] view_seg(int v);
        logic [SEGW-1:0] r;
        r = '0;
        if (v == VB) begin
            for (int d = 0; d < ND; d++) r[d*DW +: DW] = 5'b11111;
        end else if (v != VZ) begin
            for (int d = 0; d < ND; d++) r[d*DW +: DW] = digit_val(v - 1, d);
        end
        return r;
    endfunction

    task automatic add(input bit to_b, input int n, input logic r,
                       input logic a, input int s, input logic adv,
                       input int c, input int view, input logic p);
        vec_t v;
        v.rst_n = r;
        v.auto_en = a;
        v.sel = SW'(s);
        v.adv = adv;
        v.cur = SW'(c);
        v.view = view;
        v.pulse = p;
        for (int i = 0; i < n; i++) begin
            if (to_b) tab_b.push_back(v);
            else tab_a.push_back(v);
        end
    endtask

    task automatic check(input string nm, input bit is_b, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] %s: got %h want %h",
                     is_b ? "B" : "A", idx, nm, got, want);
        end
    endtask

    task automatic step(input bit is_b, input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        if (is_b) begin
            rst_b = v.rst_n;
            auto_b = v.auto_en;
            sel_b = v.sel;
            adv_b = v.adv;
        end else begin
            rst_a = v.rst_n;
            auto_a = v.auto_en;
            sel_a = v.sel;
            adv_a = v.adv;
        end
        e.seg = view_seg(v.view);
        e.cur = v.cur;
        e.pulse = v.pulse;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (is_b) begin
            check("seg", 1'b1, idx, 32'(seg_b), 32'(e.seg));
            check("cur", 1'b1, idx, 32'(cur_b), 32'(e.cur));
            check("pulse", 1'b1, idx, 32'(pulse_b), 32'(e.pulse));
        end else begin
            check("seg", 1'b0, idx, 32'(seg_a), 32'(e.seg));
            check("cur", 1'b0, idx, 32'(cur_a), 32'(e.cur));
            check("pulse", 1'b0, idx, 32'(pulse_a), 32'(e.pulse));
        end
    endtask

    initial begin
        for (int m = 0; m < NM; m++)
            for (int d = 0; d < ND; d++)
                mode_data[(m*ND+d)*DW +: DW] = digit_val(m, d);

        // DUT A: reset, then first mode-0 output
        add(0, 3, 0, 0, 0, 0, 0, VZ, 0);
        add(0, 2, 1, 0, 0, 0, 0, VM0, 0);
        // manual 0 -> 2 with two blank clocks
        add(0, 2, 1, 0, 2, 0, 2, VB, 0);
        add(0, 1, 1, 0, 2, 0, 2, VM2, 1);
        add(0, 1, 1, 0, 2, 0, 2, VM2, 0);
        // auto rotation 2 -> 0 -> 1 -> 2
        add(0, 7, 1, 1, 2, 0, 2, VM2, 0);
        add(0, 2, 1, 1, 2, 0, 0, VB, 0);
        add(0, 1, 1, 1, 2, 0, 0, VM0, 1);
        add(0, 7, 1, 1, 2, 0, 0, VM0, 0);
        add(0, 2, 1, 1, 2, 0, 1, VB, 0);
        add(0, 1, 1, 1, 2, 0, 1, VM1, 1);
        add(0, 7, 1, 1, 2, 0, 1, VM1, 0);
        add(0, 2, 1, 1, 2, 0, 2, VB, 0);
        add(0, 1, 1, 1, 2, 0, 2, VM2, 1);
        add(0, 7, 1, 1, 2, 0, 2, VM2, 0);
        // advance on terminal count, then advance held into the blank
        add(0, 2, 1, 1, 2, 1, 0, VB, 0);
        add(0, 1, 1, 1, 2, 0, 0, VM0, 1);
        // advance at dwell count 3
        add(0, 3, 1, 1, 2, 0, 0, VM0, 0);
        add(0, 1, 1, 1, 2, 1, 1, VB, 0);
        add(0, 1, 1, 1, 2, 0, 1, VB, 0);
        add(0, 1, 1, 1, 2, 0, 1, VM1, 1);
        // manual: advance ignored, illegal select ignored
        add(0, 1, 1, 0, 1, 1, 1, VM1, 0);
        add(0, 1, 1, 0, 3, 0, 1, VM1, 0);
        add(0, 1, 1, 0, 3, 1, 1, VM1, 0);
        // sel change during blank, re-evaluated afterwards
        add(0, 1, 1, 0, 0, 0, 0, VB, 0);
        add(0, 1, 1, 0, 2, 0, 0, VB, 0);
        add(0, 1, 1, 0, 2, 0, 0, VM0, 1);
        add(0, 2, 1, 0, 2, 0, 2, VB, 0);
        add(0, 1, 1, 0, 2, 0, 2, VM2, 1);
        // auto_en toggled during blank keeps full blank length
        add(0, 1, 1, 0, 1, 0, 1, VB, 0);
        add(0, 1, 1, 1, 1, 0, 1, VB, 0);
        add(0, 1, 1, 0, 1, 0, 1, VM1, 1);
        add(0, 1, 1, 0, 1, 0, 1, VM1, 0);
        // reset on the first blank clock
        add(0, 1, 1, 0, 2, 0, 2, VB, 0);
        add(0, 1, 0, 0, 2, 0, 0, VZ, 0);
        add(0, 2, 1, 0, 0, 0, 0, VM0, 0);

        // DUT B: no blanking
        add(1, 2, 0, 0, 0, 0, 0, VZ, 0);
        add(1, 1, 1, 0, 0, 0, 0, VM0, 0);
        add(1, 1, 1, 0, 1, 0, 1, VM1, 1);
        add(1, 1, 1, 0, 1, 0, 1, VM1, 0);
        add(1, 1, 1, 0, 3, 0, 1, VM1, 0);
        add(1, 1, 1, 0, 0, 0, 0, VM0, 1);
        add(1, 1, 1, 1, 0, 1, 1, VM1, 1);
        add(1, 1, 1, 1, 0, 1, 2, VM2, 1);
        add(1, 7, 1, 1, 0, 0, 2, VM2, 0);
        add(1, 1, 1, 1, 0, 1, 0, VM0, 1);
        add(1, 2, 1, 1, 0, 0, 0, VM0, 0);

        for (int i = 0; i < tab_a.size(); i++) step(1'b0, tab_a[i], i);
        for (int i = 0; i < tab_b.size(); i++) step(1'b1, tab_b[i], i);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
